// File: rtl/filter_stream_ctrl.sv
// Flow-control wrapper around a free-running 7x7 adder tree: follows accepted pixels through the
// fixed tree latency, tags each result with raster coordinates and queues it in a credit-guarded FIFO.
module filter_stream_ctrl #(
   parameter int PIX_BIT    = 8,
   parameter int MASK_WIDTH = 7,
   parameter int PIPE_LAT   = 6,
   parameter int FIFO_DEPTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_sof,
   output logic                  in_ready,
   input  logic signed [PIX_BIT:0] q_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [PIX_BIT:0] out_data,
   output logic [15:0]           out_col,
   output logic [15:0]           out_row,
   output logic                  out_border,
   output logic                  out_eof,
   output logic                  frame_done,
   output logic                  err_sof
);
   localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam int IFL_W  = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
   typedef struct packed {
      logic v;
      logic sof;
      logic eof;
   } token_t;
   typedef struct packed {
      logic [PIX_BIT:0] data;
      logic [15:0]      col;
      logic [15:0]      row;
      logic             border;
      logic             eof;
   } entry_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_in_cnt, w_cnt_nxt;
   logic              w_accept, w_issue, w_last, w_sof_err;
   logic              r_err_sof;
   token_t            r_pipe [PIPE_LAT];
   token_t            w_tail;
   logic [IFL_W-1:0]  r_inflight;
   logic [15:0]       r_col, r_row;
   entry_t            w_entry, w_head;
   entry_t            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [FCNT_W-1:0] r_fifo_cnt;
   logic              w_pop;

   assign w_accept = in_valid & in_ready;
   assign w_tail   = r_pipe[PIPE_LAT-1];

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_in_cnt  <= '0;
         r_err_sof <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue)   r_in_cnt  <= w_cnt_nxt;
         if (w_sof_err) r_err_sof <= 1'b1;
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_sof_err   = 1'b0;
      w_cnt_nxt   = r_in_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept && in_sof) begin
               w_issue   = 1'b1;
               w_cnt_nxt = CNT_W'(1);
            end else if (w_accept) begin
               w_sof_err = 1'b1;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               w_issue   = 1'b1;
               w_sof_err = in_sof;
               w_cnt_nxt = in_sof ? CNT_W'(1) : r_in_cnt + CNT_W'(1);
            end
         end
         S_FLUSH: if (r_inflight == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_last = w_issue && (w_cnt_nxt == CNT_W'(TOTAL));
      if (w_issue) w_state_nxt = w_last ? S_FLUSH : S_RUN;
   end

   // Credit counts only registered occupancy; a same-cycle pop frees its slot one cycle later.
   always_comb begin
      in_ready   = (r_state != S_FLUSH) && ((32'(r_inflight) + 32'(r_fifo_cnt)) < FIFO_DEPTH);
      frame_done = (r_state == S_FLUSH) && (r_inflight == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
         r_inflight <= '0;
      end else begin
         r_pipe[0] <= '{v: w_issue, sof: in_sof, eof: w_last};
         for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
         if (w_issue && !w_tail.v)      r_inflight <= r_inflight + IFL_W'(1);
         else if (!w_issue && w_tail.v) r_inflight <= r_inflight - IFL_W'(1);
      end
   end

   always_comb begin
      w_entry.data   = q_in;
      w_entry.col    = w_tail.sof ? '0 : r_col;
      w_entry.row    = w_tail.sof ? '0 : r_row;
      w_entry.border = (w_entry.col < 16'(MASK_WIDTH-1)) || (w_entry.row < 16'(MASK_WIDTH-1));
      w_entry.eof    = w_tail.eof;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_tail.v) begin
         if (w_tail.eof) begin
            r_col <= '0;
            r_row <= '0;
         end else if (w_entry.col == 16'(IMG_WIDTH-1)) begin
            r_col <= '0;
            r_row <= w_entry.row + 16'd1;
         end else begin
            r_col <= w_entry.col + 16'd1;
            r_row <= w_entry.row;
         end
      end
   end

   assign out_valid = (r_fifo_cnt != '0);
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_tail.v) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_tail.v && !w_pop)      r_fifo_cnt <= r_fifo_cnt + FCNT_W'(1);
         else if (!w_tail.v && w_pop) r_fifo_cnt <= r_fifo_cnt - FCNT_W'(1);
      end
   end

   // NOTE: storage is not reset; the head fields are masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_tail.v) r_mem[r_wr_ptr] <= w_entry;
   end

   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      out_data   = out_valid ? w_head.data   : '0;
      out_col    = out_valid ? w_head.col    : '0;
      out_row    = out_valid ? w_head.row    : '0;
      out_border = out_valid ? w_head.border : 1'b0;
      out_eof    = out_valid ? w_head.eof    : 1'b0;
   end

   assign err_sof = r_err_sof;

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Scoreboard bench for filter_stream_ctrl on an 8x8 frame: stimulus pushes expected entries,
// a negedge monitor pops and compares each FIFO head as the sink takes it.
module tb_filter_stream_ctrl;
   localparam int PIPE_LAT = 6;

   typedef struct packed {
      logic [8:0]  data;
      logic [15:0] col;
      logic [15:0] row;
      logic        border;
      logic        eof;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_sof, in_ready, out_valid, out_ready;
   logic        out_border, out_eof, frame_done, err_sof;
   logic [8:0]  pix, q_in, out_data;
   logic [15:0] out_col, out_row;
   logic [8:0]  dl [PIPE_LAT];

   exp_t sb [$];
   exp_t mon_e;
   int n_tests = 0, n_fail = 0;
   int n_push = 0, n_pop = 0, max_out = 0, fd_cnt = 0, cyc = 0;
   int first_acc_cyc = -1, last_acc_cyc = -1, first_ov_cyc = -1;
   int nb_cnt = 0, eof_cnt = 0;
   bit rnd_en;

   filter_stream_ctrl #(
      .PIX_BIT(8), .MASK_WIDTH(7), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(8),
      .IMG_WIDTH(8), .IMG_HEIGHT(8)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
      .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_col(out_col), .out_row(out_row), .out_border(out_border), .out_eof(out_eof),
      .frame_done(frame_done), .err_sof(err_sof)
   );

   always #5 clk = ~clk;

   // Free-running tree model: q_in is the pixel presented PIPE_LAT cycles earlier.
   always @(posedge clk) begin
      dl[0] <= pix;
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
   end
   assign q_in = dl[PIPE_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && frame_done) fd_cnt++;
      if (!reset && out_valid && first_acc_cyc >= 0 && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {63'd0, out_valid}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("out_data",   {55'd0, out_data},   {55'd0, mon_e.data});
            check("out_col",    {48'd0, out_col},    {48'd0, mon_e.col});
            check("out_row",    {48'd0, out_row},    {48'd0, mon_e.row});
            check("out_border", {63'd0, out_border}, {63'd0, mon_e.border});
            check("out_eof",    {63'd0, out_eof},    {63'd0, mon_e.eof});
            if (!out_border) nb_cnt++;
            if (out_eof)     eof_cnt++;
         end
         n_pop++;
      end
   end

   always @(posedge clk) begin
      #2;
      if ((n_push - n_pop) > max_out) max_out = n_push - n_pop;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_pixel(input logic [8:0] v, input logic sof, input bit tok, input exp_t e);
      int w = 0;
      in_valid = 1'b1;
      in_sof   = sof;
      pix      = v;
      @(negedge clk);
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      end else begin
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
         if (tok) begin
            sb.push_back(e);
            n_push++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Pixel k carries in_sof at k==0 and k==sof_at; coordinates restart at the second sof.
   task automatic send_frame(input int n, input int sof_at, input int seed);
      exp_t e;
      int   p;
      @(posedge clk);
      #1;
      for (int k = 0; k < n; k++) begin
         p = (sof_at >= 0 && k >= sof_at) ? k - sof_at : k;
         e.data   = 9'(k * 37 + seed);
         e.col    = 16'(p % 8);
         e.row    = 16'(p / 8);
         e.border = ((p % 8) < 6) || ((p / 8) < 6);
         e.eof    = (p == 63);
         send_pixel(e.data, (k == 0) || (k == sof_at), 1'b1, e);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic wait_done(input int base);
      for (int i = 0; i < 400 && fd_cnt == base; i++) @(negedge clk);
      check("frame_done_seen", {63'd0, fd_cnt > base}, 64'd1);
   endtask

   task automatic drain(input int fd_base);
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("drain_empty", 64'(sb.size()), 64'd0);
      check("drain_out_valid", {63'd0, out_valid}, 64'd0);
      check("frame_done_pulses", 64'(fd_cnt - fd_base), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      n_pop = n_push;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int base, fdb;
      exp_t dummy;
      dummy = '0;
      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1; pix = '0; rnd_en = 1'b0;
      #1;
      check("reset_in_ready",  {63'd0, in_ready},   64'd1);
      check("reset_out_valid", {63'd0, out_valid},  64'd0);
      check("reset_frame_done",{63'd0, frame_done}, 64'd0);
      check("reset_err_sof",   {63'd0, err_sof},    64'd0);
      check("reset_head", {21'd0, out_data, out_col, out_row, out_border, out_eof}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: full frame, sink always ready
      base = n_pop; fdb = fd_cnt; nb_cnt = 0; eof_cnt = 0;
      send_frame(64, -1, 5);
      check("t1_throughput", 64'(last_acc_cyc - first_acc_cyc), 64'd63);
      wait_done(fdb);
      drain(fdb);
      check("t1_outputs", 64'(n_pop - base), 64'd64);
      check("t1_first_latency", 64'(first_ov_cyc - first_acc_cyc), 64'd7);
      check("t1_non_border", 64'(nb_cnt), 64'd4);
      check("t1_eof_count", 64'(eof_cnt), 64'd1);
      check("t1_err_sof", {63'd0, err_sof}, 64'd0);

      // 2: sink stalled, credit must stop the source after 8 accepts
      base = n_push; fdb = fd_cnt;
      out_ready = 1'b0;
      fork
         send_frame(64, -1, 100);
         begin
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (in_valid && !in_ready) break;
            end
            check("t2_accepts_before_stall", 64'(n_push - base), 64'd8);
            repeat (20) @(negedge clk);
            check("t2_hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("t2_hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("t2_hold_accepts", 64'(n_push - base), 64'd8);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_done(fdb);
      drain(fdb);

      // 3: sink toggles randomly, source continuous
      fdb = fd_cnt; max_out = 0; rnd_en = 1'b1;
      fork
         begin
            send_frame(64, -1, 211);
            wait_done(fdb);
            rnd_en = 1'b0;
         end
         while (rnd_en) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
         end
      join
      out_ready = 1'b1;
      drain(fdb);
      check("t3_credit_bound", {63'd0, max_out <= 8}, 64'd1);
      check("t3_err_sof", {63'd0, err_sof}, 64'd0);

      // 4: stray pixel in IDLE, then a clean frame
      fdb = fd_cnt;
      send_pixel(9'h1AB, 1'b0, 1'b0, dummy);
      in_valid = 1'b0;
      check("t4_err_sof", {63'd0, err_sof}, 64'd1);
      base = n_pop;
      send_frame(64, -1, 77);
      wait_done(fdb);
      drain(fdb);
      check("t4_outputs", 64'(n_pop - base), 64'd64);

      // 5: restart sof at pixel 20
      do_reset();
      check("t5_err_cleared", {63'd0, err_sof}, 64'd0);
      base = n_pop; fdb = fd_cnt;
      send_frame(84, 20, 9);
      check("t5_err_sof", {63'd0, err_sof}, 64'd1);
      wait_done(fdb);
      drain(fdb);
      check("t5_outputs", 64'(n_pop - base), 64'd84);

      // 6: reset with 3 tokens in flight and 2 in the FIFO
      out_ready = 1'b0;
      send_frame(5, -1, 300);
      repeat (3) @(posedge clk);
      #1;
      check("t6_pre_out_valid", {63'd0, out_valid}, 64'd1);
      reset = 1'b1;
      sb.delete();
      n_pop = n_push;
      #1;
      check("t6_out_valid", {63'd0, out_valid}, 64'd0);
      check("t6_in_ready",  {63'd0, in_ready},  64'd1);
      check("t6_head", {21'd0, out_data, out_col, out_row, out_border, out_eof}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      check("t6_in_ready_release", {63'd0, in_ready}, 64'd1);
      repeat (20) @(posedge clk);
      #1;
      check("t6_no_stale", {63'd0, out_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
